// File: rtl/hamming_decoder72_pipe.sv
// Two-stage pipelined (72,64) SECDED decoder with valid/ready handshakes on both
// sides and saturating counters of corrected and uncorrectable words.
// Stage 1 captures raw data, syndrome and overall parity; stage 2 applies the
// correction and registers the result and error flags.
module hamming_decoder72_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [71:0] codeWord,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] dataOut,
  output logic        err_single,
  output logic        err_double,
  output logic [6:0]  err_pos,
  input  logic        clr_counts,
  output logic [15:0] ce_count,
  output logic [15:0] de_count
);

  // Pull the 64 data bits out of the non-power-of-two positions 3..71.
  function automatic logic [63:0] extractData(input logic [71:0] cw);
    logic [63:0] d;
    int          j;
    d = '0;
    j = 0;
    for (int i = 1; i < 72; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j[5:0]] = cw[i[6:0]];
        j++;
      end
    end
    return d;
  endfunction

  // Syndrome: XOR of the indices of every set position 1..71.
  function automatic logic [6:0] syndrome(input logic [71:0] cw);
    logic [6:0] s;
    s = '0;
    for (int i = 1; i < 72; i++) begin
      if (cw[i[6:0]]) s = s ^ i[6:0];
    end
    return s;
  endfunction

  logic        s1Valid_q;
  logic [63:0] s1Data_q, s1Data_d;
  logic [6:0]  s1Syn_q, s1Syn_d;
  logic        s1Par_q, s1Par_d;

  logic        s1Load, s2Load, outFire;
  logic        single_d, double_d;
  logic [6:0]  pos_d;
  logic [71:0] flipMask;
  logic [63:0] corrData_d;

  // Handshake control: stage 2 loads when empty or draining, stage 1 when empty or advancing.
  always_comb begin
    s2Load   = !out_valid || out_ready;
    s1Load   = !s1Valid_q || s2Load;
    in_ready = s1Load;
    outFire  = out_valid && out_ready;
  end

  // Stage 1 combinational decode of the incoming code word.
  always_comb begin
    s1Data_d = extractData(codeWord);
    s1Syn_d  = syndrome(codeWord);
    s1Par_d  = ^codeWord;
  end

  // Stage 1 register: raw data, syndrome, parity and valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1Data_q  <= '0;
      s1Syn_q   <= '0;
      s1Par_q   <= 1'b0;
    end else if (s1Load) begin
      s1Valid_q <= in_valid;
      if (in_valid) begin
        s1Data_q <= s1Data_d;
        s1Syn_q  <= s1Syn_d;
        s1Par_q  <= s1Par_d;
      end
    end
  end

  // Classify the error and build the corrected data word.
  always_comb begin
    single_d = s1Par_q && (s1Syn_q < 7'd72);
    double_d = (!s1Par_q && (s1Syn_q != 7'd0)) || (s1Par_q && (s1Syn_q >= 7'd72));
    pos_d    = single_d ? s1Syn_q : 7'd0;
    flipMask = '0;
    // A syndrome of 0 flips position 0, which carries no data, so data is unchanged.
    if (single_d) flipMask = 72'(1) << s1Syn_q;
    corrData_d = s1Data_q ^ extractData(flipMask);
  end

  // Stage 2 register: corrected data, flags and output valid; held under back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      dataOut    <= '0;
      err_single <= 1'b0;
      err_double <= 1'b0;
      err_pos    <= '0;
    end else if (s2Load) begin
      out_valid <= s1Valid_q;
      if (s1Valid_q) begin
        dataOut    <= corrData_d;
        err_single <= single_d;
        err_double <= double_d;
        err_pos    <= pos_d;
      end
    end
  end

  // Saturating status counters; clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_count <= '0;
      de_count <= '0;
    end else if (clr_counts) begin
      ce_count <= '0;
      de_count <= '0;
    end else if (outFire) begin
      if (err_single && (ce_count != 16'hFFFF)) ce_count <= ce_count + 16'd1;
      if (err_double && (de_count != 16'hFFFF)) de_count <= de_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hamming_decoder72_pipe.sv
// Self-checking bench for hamming_decoder72_pipe: a directed vector table streamed
// through the pipe plus hand-written latency, back-pressure, counter and reset sequences.
module tb_hamming_decoder72_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] codeWord;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] dataOut;
  logic        err_single;
  logic        err_double;
  logic [6:0]  err_pos;
  logic        clr_counts;
  logic [15:0] ce_count;
  logic [15:0] de_count;

  hamming_decoder72_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .codeWord   (codeWord),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dataOut    (dataOut),
    .err_single (err_single),
    .err_double (err_double),
    .err_pos    (err_pos),
    .clr_counts (clr_counts),
    .ce_count   (ce_count),
    .de_count   (de_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] cw;
    logic [63:0] data;
    logic        sgl;
    logic        dbl;
    logic [6:0]  pos;
  } vecT;

  int  nAssert = 0;
  int  nFail   = 0;
  bit  monEn   = 1'b0;
  vecT expQ[$];
  vecT monE;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoder used only to build stimulus code words.
  function automatic logic [71:0] enc(input logic [63:0] d);
    logic [71:0] c;
    logic        p;
    int          j;
    c = '0;
    j = 0;
    for (int i = 1; i < 72; i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 7; k++) begin
      p = 1'b0;
      for (int i = 1; i < 72; i++) begin
        if (((i >> k) & 1) == 1 && (i & (i - 1)) != 0) p = p ^ c[i];
      end
      c[1 << k] = p;
    end
    c[0] = ^c[71:1];
    return c;
  endfunction

  function automatic vecT mk(input logic [71:0] cw, input logic [63:0] d, input logic s,
                             input logic db, input logic [6:0] pos);
    vecT v;
    v.cw = cw; v.data = d; v.sgl = s; v.dbl = db; v.pos = pos;
    return v;
  endfunction

  // Scoreboard: every output handshake must match the oldest accepted word.
  always @(negedge clk) begin
    if (monEn && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        nAssert++;
        nFail++;
        $display("FAIL unexpected_output: got data %0h expected no output", dataOut);
      end else begin
        monE = expQ.pop_front();
        chk("dataOut", 72'(dataOut), 72'(monE.data));
        chk("err_single", 72'(err_single), 72'(monE.sgl));
        chk("err_double", 72'(err_double), 72'(monE.dbl));
        chk("err_pos", 72'(err_pos), 72'(monE.pos));
      end
    end
  end

  task automatic sendWord(input vecT v);
    logic acc;
    int   n;
    in_valid = 1'b1;
    codeWord = v.cw;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("send_timeout", 72'(0), 72'(1));
    else expQ.push_back(v);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 72'(0), 72'(1));
    @(posedge clk);
    #1;
  endtask

  // Accept-to-output latency: out_valid low one cycle after accept, high two cycles after.
  task automatic checkLatency(input vecT v);
    monEn    = 1'b0;
    in_valid = 1'b1;
    codeWord = v.cw;
    @(negedge clk);
    chk("lat_in_ready", 72'(in_ready), 72'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_valid_early", 72'(out_valid), 72'(0));
    @(negedge clk);
    chk("lat_valid", 72'(out_valid), 72'(1));
    chk("lat_data", 72'(dataOut), 72'(v.data));
    chk("lat_single", 72'(err_single), 72'(v.sgl));
    chk("lat_pos", 72'(err_pos), 72'(v.pos));
    @(posedge clk);
    #1;
    monEn = 1'b1;
  endtask

  vecT         tbl[78];
  vecT         bp[4];
  logic [71:0] cwA;
  logic [63:0] hold;
  logic        acc;
  int          idx, accepted;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; codeWord = '0; out_ready = 1'b1; clr_counts = 1'b0;

    // Table: clean word, full single-bit sweep, doubles, triple-looking uncorrectable.
    cwA    = enc(64'hAAAA_AAAA_AAAA_AAAA);
    tbl[0] = mk(cwA, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0, 7'd0);
    for (int i = 0; i < 72; i++)
      tbl[1 + i] = mk(cwA ^ (72'(1) << i), 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b0, 7'(i));
    // Positions 3 and 10 are data bits 0 and 5, so raw data is 0x21.
    tbl[73] = mk(enc(64'h0) ^ (72'(1) << 3) ^ (72'(1) << 10), 64'h21, 1'b0, 1'b1, 7'd0);
    tbl[74] = mk(72'hF, 64'h1, 1'b0, 1'b0, 7'd0);
    tbl[75] = mk(cwA ^ 72'h6, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b1, 7'd0);
    // Flips at 0, 8, 64: odd parity with syndrome 72, outside the code.
    tbl[76] = mk(cwA ^ (72'(1) << 64) ^ (72'(1) << 8) ^ 72'h1, 64'hAAAA_AAAA_AAAA_AAAA,
                 1'b0, 1'b1, 7'd0);
    tbl[77] = mk(enc(64'h0123_4567_89AB_CDEF), 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 7'd0);

    // Reset state.
    #2;
    chk("rst_out_valid", 72'(out_valid), 72'(0));
    chk("rst_dataOut", 72'(dataOut), 72'(0));
    chk("rst_flags", 72'({err_single, err_double}), 72'(0));
    chk("rst_err_pos", 72'(err_pos), 72'(0));
    chk("rst_counts", 72'({ce_count, de_count}), 72'(0));
    chk("rst_in_ready", 72'(in_ready), 72'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Clean flow with latency check.
    checkLatency(tbl[0]);
    chk("clean_ce_count", 72'(ce_count), 72'(0));

    // Stream the table back to back.
    for (int i = 0; i < 78; i++) sendWord(tbl[i]);
    drain();
    chk("table_ce_count", 72'(ce_count), 72'(72));
    chk("table_de_count", 72'(de_count), 72'(3));

    // Back-pressure: 4 words offered with out_ready low, then released.
    for (int k = 0; k < 4; k++) begin
      bp[k] = mk(enc(64'h1111_1111_1111_1111 * (k + 1)), 64'h1111_1111_1111_1111 * (k + 1),
                 1'b0, 1'b0, 7'd0);
    end
    out_ready = 1'b0;
    idx = 0; accepted = 0;
    in_valid = 1'b1;
    codeWord = bp[0].cw;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (c == 2) hold = dataOut;
      if (c == 3) begin
        chk("bp_accepts", 72'(accepted), 72'(2));
        chk("bp_in_ready", 72'(in_ready), 72'(0));
        chk("bp_hold_valid", 72'(out_valid), 72'(1));
        chk("bp_hold_data", 72'(dataOut), 72'(hold));
        chk("bp_first_data", 72'(dataOut), 72'(bp[0].data));
      end
      if (c >= 4) chk("bp_no_gap", 72'(out_valid), 72'(1));
      @(posedge clk);
      #1;
      if (acc) begin
        expQ.push_back(bp[idx]);
        idx++;
        accepted++;
        if (idx < 4) codeWord = bp[idx].cw;
        else in_valid = 1'b0;
      end
      if (c == 3) out_ready = 1'b1;
    end
    drain();
    chk("bp_all_accepted", 72'(accepted), 72'(4));

    // Counter saturation through repeated single-bit errors.
    clr_counts = 1'b1;
    @(posedge clk);
    #1;
    clr_counts = 1'b0;
    chk("clr_counts", 72'({ce_count, de_count}), 72'(0));
    for (int k = 0; k < 65537; k++) sendWord(tbl[6]);
    drain();
    chk("ce_saturate", 72'(ce_count), 72'(16'hFFFF));
    sendWord(tbl[40]);
    drain();
    chk("ce_stay_sat", 72'(ce_count), 72'(16'hFFFF));
    chk("de_untouched", 72'(de_count), 72'(0));

    // Clear concurrent with an error handshake.
    sendWord(tbl[10]);
    @(posedge clk);
    #1;
    clr_counts = 1'b1;
    @(negedge clk);
    chk("clr_concurrent_fire", 72'(out_valid && out_ready), 72'(1));
    @(posedge clk);
    #1;
    clr_counts = 1'b0;
    chk("clr_wins", 72'({ce_count, de_count}), 72'(0));
    drain();

    // One corrected word, then reset with two words in flight.
    sendWord(tbl[20]);
    drain();
    chk("ce_one", 72'(ce_count), 72'(1));
    monEn = 1'b0;
    in_valid = 1'b1;
    codeWord = tbl[30].cw;
    @(negedge clk);
    @(posedge clk);
    #1;
    codeWord = tbl[31].cw;
    @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("inflight_valid", 72'(out_valid), 72'(1));
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 72'(out_valid), 72'(0));
    chk("rst_async_in_ready", 72'(in_ready), 72'(1));
    chk("rst_async_counts", 72'({ce_count, de_count}), 72'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    checkLatency(tbl[50]);
    chk("post_rst_ce", 72'(ce_count), 72'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
